// File: rtl/fold_mac_ctrl.sv
// fold_mac_ctrl: sequential single-multiplier FIR controller.
// Steps one MAC per cycle through the delay line against an externally registered coefficient mux.
`default_nettype none

module fold_mac_ctrl #(
  parameter int TAPS = 24,
  parameter int DW   = 8,
  parameter int CW   = 10,
  parameter int AW   = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] x_in,
  output logic                 in_ready,
  output logic [5:0]           cnt,
  input  logic signed [CW-1:0] coefficient,
  output logic signed [AW-1:0] y_out,
  output logic                 out_valid
);

  localparam int         PW   = CW + DW;
  localparam int         IW   = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [5:0] LAST = 6'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [5:0]            cnt_nxt;
  logic                  accept, acc_en, done;
  logic signed [DW-1:0]  dline [TAPS];
  logic signed [DW-1:0]  tap, tap_sel;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  acc, prod_ext, sum;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The coefficient for index k arrives one cycle after cnt==k, together with
  // the tap captured on the same edge, so accumulation starts at the second RUN edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_en    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
          cnt_nxt   = 6'd0;
        end
      end
      RUN: begin
        acc_en = (cnt != 6'd0);
        if (cnt == LAST) begin
          state_nxt = FLUSH;
          cnt_nxt   = 6'd0;
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end
      FLUSH: begin
        acc_en    = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 6'd0;
      end
    endcase
  end

  always_comb begin
    tap_sel = '0;
    if ({1'b0, cnt} < 7'(TAPS))
      tap_sel = dline[cnt[IW-1:0]];
  end

  assign prod     = PW'(coefficient) * PW'(tap);
  assign prod_ext = AW'(prod);
  assign sum      = acc + prod_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++)
        dline[k] <= '0;
      tap       <= '0;
      acc       <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      tap       <= tap_sel;
      out_valid <= done;
      if (accept) begin
        dline[0] <= x_in;
        for (int k = 1; k < TAPS; k++)
          dline[k] <= dline[k-1];
        acc <= '0;
      end else if (acc_en) begin
        acc <= sum;
      end
      // Final product folds straight into the output so y_out lands with out_valid.
      if (done)
        y_out <= sum;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fold_mac_ctrl.sv
// tb_fold_mac_ctrl: table-driven bench for fold_mac_ctrl with a registered coefficient mux model.
`default_nettype none

module tb_fold_mac_ctrl;

  localparam int TAPS = 24;
  localparam int DW   = 8;
  localparam int CW   = 10;
  localparam int AW   = 23;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] x_in = '0;
  logic                 in_ready;
  logic [5:0]           cnt;
  logic signed [CW-1:0] coefficient = '0;
  logic signed [AW-1:0] y_out;
  logic                 out_valid;

  bit ext = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int base [12] = '{-1, -2, 4, 5, -8, -11, 15, 20, -29, -43, 75, 231};
  int b [TAPS];

  typedef struct {
    logic signed [DW-1:0] x;
    logic signed [AW-1:0] y;
    bit                   chk;
    bit                   ext;
  } vec_t;

  vec_t vt [72];

  fold_mac_ctrl #(.TAPS(TAPS), .DW(DW), .CW(CW), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .x_in        (x_in),
    .in_ready    (in_ready),
    .cnt         (cnt),
    .coefficient (coefficient),
    .y_out       (y_out),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Coefficient mux: registered lookup of b[cnt].
  always @(posedge clk) begin
    if (ext)
      coefficient <= CW'(-512);
    else if (cnt < 6'(TAPS))
      coefficient <= CW'(b[cnt[4:0]]);
    else
      coefficient <= '0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Accepts one sample, holds in_valid high with junk while busy, then checks latency and y_out.
  task automatic run_sample(input vec_t v, input string nm);
    int  n;
    int  lat;
    n = 0;
    ext = v.ext;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check({nm, "_ready_timeout"}, 0, 1);
    in_valid = 1'b1;
    x_in     = v.x;
    @(posedge clk);
    #1;
    x_in = -8'sd77;
    lat  = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    in_valid = 1'b0;
    x_in     = '0;
    check({nm, "_latency"}, lat, 25);
    if (v.chk) check({nm, "_y"}, longint'(y_out), longint'(v.y));
  endtask

  initial begin
    int acc_q[$];
    int ov_q[$];
    int low_cnt;
    int n;
    bit seen;

    for (int k = 0; k < TAPS; k++)
      b[k] = (k < 12) ? base[k] : base[TAPS - 1 - k];

    for (int i = 0; i < 24; i++) begin
      vt[i].x        = (i == 0) ? 8'sd1 : 8'sd0;
      vt[i].y        = AW'(b[i]);
      vt[i].chk      = 1'b1;
      vt[i].ext      = 1'b0;
      vt[24+i].x     = 8'sd127;
      vt[24+i].y     = 23'sd65024;
      vt[24+i].chk   = (i == 23);
      vt[24+i].ext   = 1'b0;
      vt[48+i].x     = -8'sd128;
      vt[48+i].y     = 23'sd1572864;
      vt[48+i].chk   = (i == 23);
      vt[48+i].ext   = 1'b1;
    end

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_cnt", cnt, 0);
    check("rst_y_out", longint'(y_out), 0);
    check("rst_out_valid", out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 72; i++)
      run_sample(vt[i], $sformatf("vec%0d", i));

    // Continuous in_valid: acceptances every 26 cycles, out_valid 25 after each.
    ext      = 1'b0;
    x_in     = '0;
    in_valid = 1'b1;
    low_cnt  = 0;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      if (out_valid && acc_q.size() > 0) ov_q.push_back(cyc);
      if (in_ready) acc_q.push_back(cyc + 1);
      else if (acc_q.size() == 1) low_cnt++;
    end
    in_valid = 1'b0;
    check("cont_accept_count", acc_q.size(), 4);
    check("cont_ov_count", ov_q.size(), 3);
    if (acc_q.size() >= 3) begin
      check("cont_spacing0", acc_q[1] - acc_q[0], 26);
      check("cont_spacing1", acc_q[2] - acc_q[1], 26);
    end
    if (acc_q.size() >= 2 && ov_q.size() >= 2) begin
      check("cont_lat0", ov_q[0] - acc_q[0], 25);
      check("cont_lat1", ov_q[1] - acc_q[1], 25);
    end
    check("cont_ready_low", low_cnt, 25);

    // Reset mid-run at cnt==10.
    @(posedge clk);
    #1;
    while (!in_ready) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    x_in     = 8'sd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x_in     = '0;
    n = 0;
    while (cnt != 6'd10 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("midrun_cnt_reached", cnt, 10);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_cnt", cnt, 0);
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_y_out", longint'(y_out), 0);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrun_no_out_valid", seen, 0);

    for (int i = 0; i < 24; i++)
      run_sample(vt[i], $sformatf("post_rst_imp%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
